// File: rtl/ru_write_sequencer.sv
// ru_write_sequencer
//
// Owns the single write port of the 32x32 register unit. Sits between the
// core writeback stage and the register unit and drives its rd / DataWR /
// RUWr inputs.
//
// The core writeback path has priority on the port. An auxiliary requester
// (multi-cycle unit, loader, debug) is buffered in a small FIFO. If the head
// entry loses to the core for STARVE_LIMIT consecutive cycles, it is forced
// through and the core is stalled for that one cycle.
//
// Build option RU_INIT_CLEAR_EN:
//   defined   - after reset, an INIT sweep writes x1..x31 (x2 = SP_INIT,
//               all others 0) before normal operation starts.
//   undefined - no sweep. The block runs normally from the first cycle
//               after reset, and register contents are left to the
//               register unit's own initialisation.
//
// Ports:
//   clk        - clock; all state updates on the posedge
//   rst        - synchronous active-high reset
//   core_we    - core writeback request this cycle
//   core_rd    - core destination register
//   core_data  - core writeback data
//   core_stall - core must hold; its write is not performed this cycle
//   aux_valid  - aux write request
//   aux_ready  - aux request accepted when aux_valid && aux_ready
//   aux_rd     - aux destination register
//   aux_data   - aux write data
//   ru_rd      - register unit rd
//   ru_data    - register unit DataWR
//   ru_wr      - register unit RUWr
//   init_done  - registered; high once the block is in normal operation
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping x1..x31 to their initial values (sweep build only)
// ST_RUN  | normal arbitration between core and aux FIFO

module ru_write_sequencer #(
`ifdef RU_INIT_CLEAR_EN
    parameter logic [31:0] SP_INIT      = 32'h0000_0200,
`endif
    parameter int          DEPTH        = 2,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_we,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_data,
    output logic        core_stall,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_data,
    output logic [4:0]  ru_rd,
    output logic [31:0] ru_data,
    output logic        ru_wr,
    output logic        init_done
);

    localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]    FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;
    logic          init_done_q;

    logic run;
    logic active;
    logic empty;
    logic full;
    logic force_aux;
    logic grant_core;
    logic grant_aux;
    logic push;
    logic pop;

`ifdef RU_INIT_CLEAR_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state;
    logic [4:0] idx;

    assign run = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            idx         <= 5'd1;
            init_done_q <= 1'b0;
        end else if (state == ST_INIT) begin
            idx <= idx + 5'd1;
            if (idx == 5'd31) begin
                state       <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end
    end
`else
    assign run = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end
`endif

    assign init_done = init_done_q;

    assign active = !rst && run;
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);

    // Forced aux grant wins over the core; otherwise a real core write
    // (rd != 0) wins, and aux fills any cycle the core leaves unused.
    assign force_aux  = active && !empty && (starve_cnt == STARVE_MAX);
    assign grant_core = active && !force_aux && core_we && (core_rd != 5'd0);
    assign grant_aux  = active && !empty && !grant_core;

    // Readiness is taken from the pre-pop occupancy, so a full FIFO never
    // accepts even while it is draining. Writes to x0 complete the handshake
    // but are dropped here.
    assign push = active && aux_valid && !full && (aux_rd != 5'd0);
    assign pop  = grant_aux;

    always_comb begin
        ru_wr      = 1'b0;
        ru_rd      = 5'd0;
        ru_data    = 32'd0;
        core_stall = 1'b1;
        aux_ready  = 1'b0;
        if (active) begin
            core_stall = force_aux;
            aux_ready  = !full;
            if (grant_core) begin
                ru_wr   = 1'b1;
                ru_rd   = core_rd;
                ru_data = core_data;
            end else if (grant_aux) begin
                ru_wr   = 1'b1;
                ru_rd   = fifo_rd[head];
                ru_data = fifo_data[head];
            end
        end
`ifdef RU_INIT_CLEAR_EN
        else if (!rst) begin
            ru_wr   = 1'b1;
            ru_rd   = idx;
            ru_data = (idx == 5'd2) ? SP_INIT : 32'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= aux_rd;
            fifo_data[tail] <= aux_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (grant_aux) begin
                starve_cnt <= '0;
            end else if (!empty && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ru_write_sequencer.sv
module tb_ru_write_sequencer;

    localparam int          DEPTH        = 2;
    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] SP_VAL       = 32'h0000_0200;
`ifdef RU_INIT_CLEAR_EN
    localparam bit          SWEEP        = 1'b1;
`else
    localparam bit          SWEEP        = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        core_stall;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic [4:0]  ru_rd;
    logic [31:0] ru_data;
    logic        ru_wr;
    logic        init_done;

    ru_write_sequencer #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_data  (core_data),
        .core_stall (core_stall),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_rd     (aux_rd),
        .aux_data   (aux_data),
        .ru_rd      (ru_rd),
        .ru_data    (ru_data),
        .ru_wr      (ru_wr),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int   cyc;
        logic stall;
        logic ready;
        logic in_rst;
        int   done;
    } ctl_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    wr_t  wr_q[$];
    ctl_t ctl_q[$];
    ent_t m_q[$];

    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int m_done  = -1;
    int m_sweep = 0;
    int m_lost  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic expect_write(input logic [4:0] rd_v, input logic [31:0] data_v);
        wr_t w;
        w.cyc  = cyc;
        w.rd   = rd_v;
        w.data = data_v;
        wr_q.push_back(w);
    endtask

    task automatic grant_head();
        ent_t e;
        e = m_q.pop_front();
        expect_write(e.rd, e.data);
        m_lost = 0;
    endtask

    // One clock cycle: drive inputs, then predict this cycle's behaviour.
    task automatic step(input logic r, input logic cwe, input logic [4:0] crd,
                        input logic [31:0] cdat, input logic av,
                        input logic [4:0] ard, input logic [31:0] adat);
        ctl_t c;
        ent_t e;
        bit   ready;
        @(posedge clk);
        #1;
        rst       = r;
        core_we   = cwe;
        core_rd   = crd;
        core_data = cdat;
        aux_valid = av;
        aux_rd    = ard;
        aux_data  = adat;
        cyc++;
        c.cyc    = cyc;
        c.in_rst = r;
        c.done   = m_done;
        c.stall  = 1'b1;
        c.ready  = 1'b0;
        if (r) begin
            m_q.delete();
            m_lost  = 0;
            m_done  = 0;
            m_sweep = SWEEP ? 1 : 0;
        end else if (m_sweep != 0) begin
            expect_write(5'(m_sweep), (m_sweep == 2) ? SP_VAL : 32'd0);
            m_sweep++;
            if (m_sweep == 32) begin
                m_sweep = 0;
                m_done  = 1;
            end
        end else begin
            ready   = (m_q.size() < DEPTH);
            c.ready = ready;
            c.stall = 1'b0;
            if (m_q.size() > 0 && m_lost >= STARVE_LIMIT) begin
                c.stall = 1'b1;
                grant_head();
            end else if (cwe && crd != 5'd0) begin
                expect_write(crd, cdat);
                if (m_q.size() > 0) m_lost++;
            end else if (m_q.size() > 0) begin
                grant_head();
            end
            if (av && ready && ard != 5'd0) begin
                e.rd   = ard;
                e.data = adat;
                m_q.push_back(e);
            end
            m_done = 1;
        end
        ctl_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: control outputs every cycle, writes whenever ru_wr is high.
    initial begin
        ctl_t c;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                check("core_stall", 64'(core_stall), 64'(c.stall));
                check("aux_ready", 64'(aux_ready), 64'(c.ready));
                if (c.done >= 0) check("init_done", 64'(init_done), 64'(c.done));
                if (c.in_rst) check("reset_rd_data", {27'd0, ru_rd, ru_data}, 64'd0);
            end
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                w = wr_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_write (cycle %0d): got none expected rd=%0d data=%0h",
                         w.cyc, w.rd, w.data);
            end
            if (ru_wr === 1'b1) begin
                if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write (cycle %0d): got rd=%0d data=%0h expected none",
                             cyc, ru_rd, ru_data);
                end else begin
                    w = wr_q.pop_front();
                    check("write_rd_data", {27'd0, ru_rd, ru_data}, {27'd0, w.rd, w.data});
                end
            end
        end
    end

    initial begin
        logic        r;
        logic        cwe;
        logic        av;
        logic [4:0]  crd;
        logic [4:0]  ard;
        rst       = 1'b1;
        core_we   = 1'b0;
        core_rd   = 5'd0;
        core_data = 32'd0;
        aux_valid = 1'b0;
        aux_rd    = 5'd0;
        aux_data  = 32'd0;

        // Reset, then sweep (if built) and settle; core requests are held off.
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(SWEEP ? 33 : 3);

        // Core priority over a same-cycle aux push.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd6, 32'h0000_1234);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Starvation: core busy every cycle, one aux entry pending.
        step(1'b0, 1'b1, 5'd7, 32'h7000_0000, 1'b1, 5'd9, 32'h0000_0999);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 5'd7, 32'h7000_0000 + i, 1'b0, 5'd0, 32'd0);
        idle(2);

        // FIFO full: three push attempts with the core busy, then drain.
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd20, 32'hA0);
        step(1'b0, 1'b1, 5'd7, 32'h2, 1'b1, 5'd21, 32'hA1);
        step(1'b0, 1'b1, 5'd7, 32'h3, 1'b1, 5'd22, 32'hA2);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 5'd7, 32'h10 + i, 1'b0, 5'd0, 32'd0);
        idle(3);

        // x0: aux rd=0 is accepted and dropped; core rd=0 yields to aux.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0);
        idle(2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB11);
        step(1'b0, 1'b1, 5'd0, 32'hBAD1, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Reset with aux entries pending; with the sweep, reset again at idx 17.
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC12);
        step(1'b0, 1'b1, 5'd3, 32'h34, 1'b1, 5'd13, 32'hC13);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        if (SWEEP) begin
            idle(16);
            step(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd14, 32'hC14);
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
        idle(SWEEP ? 35 : 5);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 399) == 0);
            cwe = ($urandom_range(0, 9) < 6);
            crd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            av  = ($urandom_range(0, 1) == 1);
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            step(r, cwe, crd, $urandom, av, ard, $urandom);
        end
        idle(SWEEP ? 40 : 10);
        @(posedge clk);
        @(posedge clk);
        check("leftover_writes", 64'(wr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
